week_5_gate_test_sequencer: RTL and testbench
=============================================

WEEK_5_GATE_TEST_SEQUENCER -- requirements
Module: week_5_gate_test_sequencer

Interface
REQ-001 The module SHALL have parameter N_BITS, default 2, giving the width of the stimulus vector driven to the gate under test (1..8).
REQ-002 The module SHALL have parameter SETTLE, default 2, giving the clock cycles each vector is held before the output is sampled (1..15).
REQ-003 The module SHALL have parameter OP, default 0, selecting the golden function: 0 = NOT of dut_a[0], 1 = AND-reduce, 2 = OR-reduce, 3 = XOR-reduce of dut_a.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to run a full sweep; sampled only in IDLE or DONE.
REQ-007 dut_y  input  1  output of the gate under test.
REQ-008 dut_a  output  N_BITS  stimulus vector driven to the gate under test (registered).
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  high from sweep completion until the next start or rst.
REQ-011 all_pass  output  1  valid while done=1; high when fail_count is 0.
REQ-012 pass_count  output  N_BITS+1  number of vectors whose sampled dut_y matched the golden value.
REQ-013 fail_count  output  N_BITS+1  number of mismatching vectors.
REQ-014 err_valid  output  1  one-cycle pulse on each mismatch.
REQ-015 err_vector  output  N_BITS  dut_a value of the most recent mismatch; held until the next mismatch or clear.

Function
REQ-016 The FSM SHALL have states IDLE, SETTLE, CHECK and DONE.
REQ-017 In IDLE or DONE with start=1: dut_a<=0, pass_count<=0, fail_count<=0, err_vector<=0, done<=0, busy<=1, settle counter<=SETTLE-1, next state SETTLE.
REQ-018 In SETTLE: if counter=0, next state CHECK; otherwise decrement the counter; SETTLE therefore lasts exactly SETTLE cycles per vector.
REQ-019 In CHECK (one cycle): compare dut_y with golden(dut_a); on match pass_count+1; on mismatch fail_count+1, err_valid=1 in the following cycle, err_vector<=dut_a.
REQ-020 In CHECK, if dut_a = 2^N_BITS-1 (last vector): next state DONE, busy<=0, done<=1, dut_a held; otherwise dut_a<=dut_a+1, counter<=SETTLE-1, next state SETTLE.
REQ-021 dut_a SHALL NOT change during SETTLE or CHECK; it changes only on the CHECK->SETTLE edge or on sweep start.
REQ-022 Latency from the start-sampling edge to done=1 SHALL be 2^N_BITS*(SETTLE+1) cycles (12 with defaults).
REQ-023 start while busy=1 SHALL be ignored; it SHALL NOT restart or alter counters.
REQ-024 start in DONE SHALL restart the sweep per REQ-017; done falls on the same edge that busy rises.
REQ-025 pass_count+fail_count SHALL equal the number of completed CHECK cycles and SHALL reach 2^N_BITS at DONE without overflow.
REQ-026 all_pass SHALL be 0 whenever done=0.
REQ-027 The module SHALL wrap dut_a only via restart, never by incrementing past 2^N_BITS-1.

Reset
REQ-028 With rst=1 at a rising edge, the module SHALL enter IDLE with dut_a=0, busy=0, done=0, all_pass=0, pass_count=0, fail_count=0, err_valid=0, err_vector=0.
REQ-029 rst SHALL take priority over start and over any in-progress sweep (reset mid-SETTLE or mid-CHECK aborts without updating counters).

Verification
REQ-030 OP=0, N_BITS=2, SETTLE=2, dut_y=~dut_a[0] (inverter): pulse start -> dut_a steps 0,1,2,3 every 3 cycles; done=1 exactly 12 cycles after start edge; pass_count=4, fail_count=0, all_pass=1, no err_valid.
REQ-031 Same setup, dut_y tied 0: -> mismatches at vectors 0 and 2; err_valid pulses twice; err_vector=2 at DONE; pass_count=2, fail_count=2, all_pass=0.
REQ-032 OP=3, N_BITS=3, SETTLE=1, dut_y=^dut_a: -> done after 16 cycles, pass_count=8, fail_count=0.
REQ-033 Start held high through whole sweep: -> single sweep, counters unchanged by repeated start until DONE, then immediate restart with done falling and counters cleared.
REQ-034 rst asserted in the cycle dut_a=2 during SETTLE: -> next cycle IDLE, dut_a=0, busy=0, counts 0; subsequent start gives a complete, correct sweep.
REQ-035 Inverter DUT with dut_y delayed 1 cycle, SETTLE=1: -> all vectors pass, confirming sampling occurs only after the full settle window.

Source files
------------

// File: rtl/week_5_gate_test_sequencer.sv
// rtl/week_5_gate_test_sequencer.sv - exhaustive stimulus sweep and golden-model check of a small combinational gate
module week_5_gate_test_sequencer #(
    parameter int N_BITS = 2,
    parameter int SETTLE = 2,
    parameter int OP     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dut_y,
    output logic [N_BITS-1:0] dut_a,
    output logic              busy,
    output logic              done,
    output logic              all_pass,
    output logic [N_BITS:0]   pass_count,
    output logic [N_BITS:0]   fail_count,
    output logic              err_valid,
    output logic [N_BITS-1:0] err_vector
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [N_BITS-1:0] LAST_VEC    = '1;
    localparam logic [3:0]        SETTLE_INIT = 4'(SETTLE - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] settle_cnt;
    logic       golden;

    always_comb begin
        golden = ^dut_a;
        if (OP == 0) begin
            golden = ~dut_a[0];
        end else if (OP == 1) begin
            golden = &dut_a;
        end else if (OP == 2) begin
            golden = |dut_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_next = (dut_a == LAST_VEC) ? ST_DONE : ST_SETTLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: stimulus only moves on sweep start or on leaving CHECK, never while settling.
    always_ff @(posedge clk) begin
        if (rst) begin
            dut_a      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass_count <= '0;
            fail_count <= '0;
            err_valid  <= 1'b0;
            err_vector <= '0;
            settle_cnt <= 4'd0;
        end else begin
            err_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        dut_a      <= '0;
                        pass_count <= '0;
                        fail_count <= '0;
                        err_vector <= '0;
                        done       <= 1'b0;
                        busy       <= 1'b1;
                        settle_cnt <= SETTLE_INIT;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (dut_y == golden) begin
                        pass_count <= pass_count + 1'b1;
                    end else begin
                        fail_count <= fail_count + 1'b1;
                        err_valid  <= 1'b1;
                        err_vector <= dut_a;
                    end
                    if (dut_a == LAST_VEC) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        dut_a      <= dut_a + 1'b1;
                        settle_cnt <= SETTLE_INIT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign all_pass = done && (fail_count == '0);

endmodule

// File: tb/tb_week_5_gate_test_sequencer.sv
// tb/tb_week_5_gate_test_sequencer.sv - scoreboard bench for the gate test sequencer
module tb_week_5_gate_test_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start2;
    logic       y1, y2, y2_d;
    logic [1:0] a1, ev_vec1;
    logic [2:0] a2, ev_vec2;
    logic       busy1, done1, ap1, ev1;
    logic       busy2, done2, ap2, ev2;
    logic [2:0] pc1, fc1;
    logic [3:0] pc2, fc2;

    int errors = 0;
    int checks = 0;
    int mode1  = 0;
    int mode2  = 0;
    int err_q[$];

    always #5 clk = ~clk;

    // instance 1: inverter or stuck-at-0 gate; instance 2: XOR gate, optionally one cycle late
    assign y1 = (mode1 != 0) ? 1'b0 : ~a1[0];
    always @(posedge clk) y2_d <= ^a2;
    assign y2 = (mode2 != 0) ? y2_d : ^a2;

    week_5_gate_test_sequencer #(.N_BITS(2), .SETTLE(2), .OP(0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .dut_y(y1), .dut_a(a1),
        .busy(busy1), .done(done1), .all_pass(ap1), .pass_count(pc1),
        .fail_count(fc1), .err_valid(ev1), .err_vector(ev_vec1)
    );

    week_5_gate_test_sequencer #(.N_BITS(3), .SETTLE(1), .OP(3)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .dut_y(y2), .dut_a(a2),
        .busy(busy2), .done(done2), .all_pass(ap2), .pass_count(pc2),
        .fail_count(fc2), .err_valid(ev2), .err_vector(ev_vec2)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ev1) begin
            if (err_q.size() == 0) begin
                check("err1_unexpected", int'(ev1), 0);
            end else begin
                check("err1_vector", int'(ev_vec1), err_q.pop_front());
            end
        end
        if (ev2) check("err2_unexpected", int'(ev2), 0);
    end

    task automatic wait_done1(output int lat);
        lat = 0;
        while (!done1 && lat < 500) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run1(input int mode);
        int lat, exp_p, exp_f, last_bad;
        bit y, g;
        mode1 = mode; exp_p = 0; exp_f = 0; last_bad = 0;
        for (int v = 0; v < 4; v++) begin
            g = ((v & 1) == 0);
            y = (mode != 0) ? 1'b0 : g;
            if (y != g) begin
                err_q.push_back(v);
                exp_f++;
                last_bad = v;
            end else begin
                exp_p++;
            end
        end
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        wait_done1(lat);
        check("lat1", lat, 12);
        check("pass1", int'(pc1), exp_p);
        check("fail1", int'(fc1), exp_f);
        check("all_pass1", int'(ap1), (exp_f == 0) ? 1 : 0);
        check("busy1_done", int'(busy1), 0);
        check("err_q_empty", err_q.size(), 0);
        if (exp_f > 0) check("err_vector_done", int'(ev_vec1), last_bad);
    endtask

    task automatic run2(input int mode);
        int lat;
        mode2 = mode;
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        lat = 0;
        while (!done2 && lat < 500) begin
            @(negedge clk);
            lat++;
        end
        check("lat2", lat, 16);
        check("pass2", int'(pc2), 8);
        check("fail2", int'(fc2), 0);
        check("all_pass2", int'(ap2), 1);
    endtask

    initial begin
        int lat, n;
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dut_a", int'(a1), 0);
        check("rst_busy", int'(busy1), 0);
        check("rst_done", int'(done1), 0);
        check("rst_all_pass", int'(ap1), 0);
        check("rst_pass", int'(pc1), 0);
        check("rst_fail", int'(fc1), 0);
        check("rst_err_valid", int'(ev1), 0);
        check("rst_err_vector", int'(ev_vec1), 0);
        check("rst_done2", int'(done2), 0);
        rst = 1'b0;

        run1(0);
        run1(1);
        run2(0);
        run2(1);

        // start held high across a whole sweep, then restart from DONE
        mode1 = 0;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk);
        wait_done1(lat);
        check("hold_lat", lat, 12);
        check("hold_pass", int'(pc1), 4);
        @(negedge clk);
        check("restart_done", int'(done1), 0);
        check("restart_busy", int'(busy1), 1);
        check("restart_pass", int'(pc1), 0);
        check("restart_all_pass", int'(ap1), 0);
        start1 = 1'b0;
        wait_done1(lat);
        check("restart_lat", lat, 12);
        check("restart_pass_end", int'(pc1), 4);

        // reset in the middle of a sweep
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        n = 0;
        while (a1 != 2'd2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_vec2", int'(a1), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_dut_a", int'(a1), 0);
        check("abort_busy", int'(busy1), 0);
        check("abort_pass", int'(pc1), 0);
        check("abort_fail", int'(fc1), 0);
        run1(1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
